// File: rtl/fpu_norm_pkg.sv
// rtl/fpu_norm_pkg.sv - shared FPU normalizer widths, flag bit positions and mode encoding
package fpu_norm_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;
  localparam int LZ_W_DEF   = 5;

  // out_flags = {ovf, subnormal, zero, sticky}
  localparam int FLG_OVF  = 3;
  localparam int FLG_SUB  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_STKY = 0;

  typedef enum logic [1:0] {
    MODE_LSH  = 2'd0,
    MODE_RSH  = 2'd1,
    MODE_ZERO = 2'd2,
    MODE_INF  = 2'd3
  } norm_mode_e;

endpackage

// File: rtl/fmadd_norm_lshift.sv
// rtl/fmadd_norm_lshift.sv - combinational log-stage barrel left shifter, zero fill
module fmadd_norm_lshift #(
  parameter int MANT_W = 24,
  parameter int LZ_W   = 5
) (
  input  logic [MANT_W-1:0] i_mant,
  input  logic [LZ_W-1:0]   i_shift,
  output logic [MANT_W-1:0] o_mant
);

  logic [MANT_W-1:0] w_stage [LZ_W+1];

  assign w_stage[0] = i_mant;

  for (genvar g = 0; g < LZ_W; g++) begin : g_stage
    assign w_stage[g+1] = i_shift[g] ? (w_stage[g] << (2**g)) : w_stage[g];
  end

  assign o_mant = w_stage[LZ_W];

endmodule

// File: rtl/fmadd_lzd_normalizer.sv
// rtl/fmadd_lzd_normalizer.sv - 2-stage FMA post-add normalizer (shift clamp, then barrel shift)
// FMADD_NORM_OVF_EN enables carry-out right-shift, sticky and overflow-to-infinity handling.
module fmadd_lzd_normalizer
  import fpu_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int LZ_W   = LZ_W_DEF
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W:0]   in_mant,
  input  logic [LZ_W-1:0]   in_lz,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic [3:0]        out_flags
);

  localparam int CW = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

  logic              r_s1_vld;
  logic              r_s1_sign;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [MANT_W-1:0] r_s1_mant;
  logic [LZ_W-1:0]   r_s1_shift;
  logic              r_s1_sub;
  logic              r_s1_stky;
  norm_mode_e        r_s1_mode;
  logic              r_s2_vld;

  logic              w_s1_adv;
  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_carry;
  logic [LZ_W-1:0]   w_lz_c;
  logic [CW-1:0]     w_exp_ext;
  logic [CW-1:0]     w_lz_ext;
  logic [EXP_W:0]    w_exp_inc;
  norm_mode_e        w_mode;
  logic [LZ_W-1:0]   w_shift;
  logic [EXP_W-1:0]  w_exp_nx;
  logic [MANT_W-1:0] w_mant_s1;
  logic              w_sub;
  logic              w_stky;
  logic [MANT_W-1:0] w_lsh;
  logic [MANT_W-1:0] w_mant_nx;
  logic [3:0]        w_flags_nx;

  // Stage 1 may refill in the same cycle stage 2 drains, so throughput never drops.
  assign w_s1_adv  = !r_s2_vld || out_ready;
  assign in_ready  = !r_s1_vld || w_s1_adv;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_s1_vld && w_s1_adv;
  assign out_valid = r_s2_vld;

`ifdef FMADD_NORM_OVF_EN
  assign w_carry = in_mant[MANT_W];
`else
  logic w_unused_carry;
  assign w_unused_carry = in_mant[MANT_W];
  assign w_carry        = 1'b0;
`endif

  assign w_lz_c    = (int'(in_lz) >= MANT_W) ? LZ_W'(MANT_W - 1) : in_lz;
  assign w_exp_ext = CW'(in_exp);
  assign w_lz_ext  = CW'(w_lz_c);
  assign w_exp_inc = {1'b0, in_exp} + {{EXP_W{1'b0}}, 1'b1};

  always_comb begin
    w_mode    = MODE_LSH;
    w_shift   = '0;
    w_exp_nx  = '0;
    w_sub     = 1'b0;
    w_stky    = 1'b0;
    w_mant_s1 = in_mant[MANT_W-1:0];
    if (w_carry) begin
      w_mant_s1 = in_mant[MANT_W:1];
      w_stky    = in_mant[0];
      if (w_exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
        w_mode   = MODE_INF;
        w_exp_nx = '1;
      end else begin
        w_mode   = MODE_RSH;
        w_exp_nx = w_exp_inc[EXP_W-1:0];
      end
    end else if (in_zero) begin
      w_mode = MODE_ZERO;
    end else if (in_exp == '0) begin
      w_sub = 1'b1;
    end else if (w_exp_ext > w_lz_ext) begin
      w_shift  = w_lz_c;
      w_exp_nx = in_exp - EXP_W'(w_lz_c);
    end else begin
      // Exponent would underflow: shift only as far as the minimum normal exponent allows.
      w_shift = LZ_W'(in_exp - {{(EXP_W-1){1'b0}}, 1'b1});
      w_sub   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s1_vld   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_shift <= '0;
      r_s1_sub   <= 1'b0;
      r_s1_stky  <= 1'b0;
      r_s1_mode  <= MODE_LSH;
    end else begin
      if (in_ready) r_s1_vld <= in_valid;
      if (w_s1_load) begin
        r_s1_sign  <= in_sign;
        r_s1_exp   <= w_exp_nx;
        r_s1_mant  <= w_mant_s1;
        r_s1_shift <= w_shift;
        r_s1_sub   <= w_sub;
        r_s1_stky  <= w_stky;
        r_s1_mode  <= w_mode;
      end
    end
  end

  fmadd_norm_lshift #(
    .MANT_W (MANT_W),
    .LZ_W   (LZ_W)
  ) u_lshift (
    .i_mant  (r_s1_mant),
    .i_shift (r_s1_shift),
    .o_mant  (w_lsh)
  );

  always_comb begin
    w_mant_nx  = w_lsh;
    w_flags_nx = '0;
    case (r_s1_mode)
      MODE_LSH:  w_flags_nx[FLG_SUB] = r_s1_sub;
      MODE_RSH:  w_flags_nx[FLG_STKY] = r_s1_stky;
      MODE_ZERO: begin
        w_mant_nx            = '0;
        w_flags_nx[FLG_ZERO] = 1'b1;
      end
      MODE_INF: begin
        w_mant_nx           = '0;
        w_flags_nx[FLG_OVF] = 1'b1;
      end
      default: w_mant_nx = w_lsh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s2_vld  <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_flags <= '0;
    end else begin
      if (w_s1_adv) r_s2_vld <= r_s1_vld;
      if (w_s2_load) begin
        out_sign  <= r_s1_sign;
        out_exp   <= r_s1_exp;
        out_mant  <= w_mant_nx;
        out_flags <= w_flags_nx;
      end
    end
  end

endmodule

// File: tb/tb_fmadd_lzd_normalizer.sv
// tb/tb_fmadd_lzd_normalizer.sv - directed self-checking bench for fmadd_lzd_normalizer
module tb_fmadd_lzd_normalizer;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic [4:0]  in_lz;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic [3:0]  out_flags;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fmadd_lzd_normalizer dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_lz     (in_lz),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_flags (out_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic run1(input string tag, input logic sign, input logic [7:0] exp,
                      input logic [24:0] mant, input logic [4:0] lz, input logic zero,
                      input logic e_sign, input logic [7:0] e_exp,
                      input logic [23:0] e_mant, input logic [3:0] e_flags);
    in_valid  = 1'b1;
    in_sign   = sign;
    in_exp    = exp;
    in_mant   = mant;
    in_lz     = lz;
    in_zero   = zero;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    #1;
    chk({tag, "_v1"}, 32'(out_valid), 32'd0);
    tick;
    #1;
    chk({tag, "_v2"}, 32'(out_valid), 32'd1);
    chk({tag, "_sign"}, 32'(out_sign), 32'(e_sign));
    chk({tag, "_exp"}, 32'(out_exp), 32'(e_exp));
    chk({tag, "_mant"}, 32'(out_mant), 32'(e_mant));
    chk({tag, "_flags"}, 32'(out_flags), 32'(e_flags));
    tick;
    #1;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int          c;
    int          sent;
    int          got;
    logic        hold;
    logic [7:0]  h_exp;
    logic [23:0] h_mant;

    rst_l     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    in_lz     = '0;
    in_zero   = 1'b0;
    out_ready = 1'b1;
    tick;
    tick;
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_exp", 32'(out_exp), 32'd0);
    chk("rst_mant", 32'(out_mant), 32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    rst_l = 1'b1;
    tick;

    run1("norm",    1'b0, 8'h80, 25'h0002000, 5'd10, 1'b0, 1'b0, 8'h76, 24'h800000, 4'b0000);
    run1("sub_lim", 1'b0, 8'h03, 25'h0002000, 5'd10, 1'b0, 1'b0, 8'h00, 24'h008000, 4'b0100);
    run1("zero",    1'b1, 8'h55, 25'h0000000, 5'd31, 1'b1, 1'b1, 8'h00, 24'h000000, 4'b0010);
    run1("exp0",    1'b0, 8'h00, 25'h0000123, 5'd15, 1'b0, 1'b0, 8'h00, 24'h000123, 4'b0100);
    run1("lz_sat",  1'b0, 8'h80, 25'h0000001, 5'd31, 1'b0, 1'b0, 8'h69, 24'h800000, 4'b0000);
    run1("exp_eq",  1'b0, 8'h0A, 25'h0002000, 5'd10, 1'b0, 1'b0, 8'h00, 24'h400000, 4'b0100);
    run1("exp_gt",  1'b0, 8'h0B, 25'h0002000, 5'd10, 1'b0, 1'b0, 8'h01, 24'h800000, 4'b0000);
    run1("neg",     1'b1, 8'h90, 25'h0400000, 5'd1,  1'b0, 1'b1, 8'h8F, 24'h800000, 4'b0000);
`ifdef FMADD_NORM_OVF_EN
    run1("ovf_rsh", 1'b0, 8'hFD, 25'h1000001, 5'd3,  1'b0, 1'b0, 8'hFE, 24'h800000, 4'b0001);
    run1("ovf_inf", 1'b0, 8'hFE, 25'h1000001, 5'd3,  1'b0, 1'b0, 8'hFF, 24'h000000, 4'b1000);
    run1("ovf_ns",  1'b1, 8'h80, 25'h1000002, 5'd7,  1'b0, 1'b1, 8'h81, 24'h800001, 4'b0000);
`else
    run1("carry_ign", 1'b0, 8'h80, 25'h1002000, 5'd10, 1'b0, 1'b0, 8'h76, 24'h800000, 4'b0000);
`endif

    // Backpressure: 4 beats offered back to back, downstream stalled for the first cycles.
    c = 0; sent = 0; got = 0; hold = 1'b0; h_exp = '0; h_mant = '0;
    while (got < 4 && c < 40) begin
      in_valid  = (sent < 4);
      in_sign   = 1'b0;
      in_exp    = 8'h40 + 8'(sent);
      in_mant   = 25'h0800000 | 25'(sent);
      in_lz     = 5'd0;
      in_zero   = 1'b0;
      out_ready = (c >= 5);
      #1;
      if (hold) begin
        chk("bp_hold_vld", 32'(out_valid), 32'd1);
        chk("bp_hold_exp", 32'(out_exp), 32'(h_exp));
        chk("bp_hold_mant", 32'(out_mant), 32'(h_mant));
      end
      if (c == 2) begin
        chk("bp_rdy_low", 32'(in_ready), 32'd0);
        chk("bp_sent2", 32'(sent), 32'd2);
      end
      hold   = out_valid && !out_ready;
      h_exp  = out_exp;
      h_mant = out_mant;
      if (out_valid && out_ready) begin
        chk("bp_exp", 32'(out_exp), 32'(8'h40 + 8'(got)));
        chk("bp_mant", 32'(out_mant), 32'(24'h800000 | 24'(got)));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick;
      c++;
    end
    chk("bp_got", 32'(got), 32'd4);
    chk("bp_sent", 32'(sent), 32'd4);
    in_valid = 1'b0;
    #1;
    chk("bp_nodup", 32'(out_valid), 32'd0);
    tick;

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_exp    = 8'h20;
    in_mant   = 25'h0800000;
    in_lz     = 5'd0;
    tick;
    in_exp = 8'h21;
    tick;
    in_valid = 1'b0;
    #1;
    chk("rf_full_vld", 32'(out_valid), 32'd1);
    chk("rf_full_rdy", 32'(in_ready), 32'd0);
    rst_l = 1'b0;
    #1;
    chk("rf_vld", 32'(out_valid), 32'd0);
    chk("rf_rdy", 32'(in_ready), 32'd1);
    chk("rf_exp", 32'(out_exp), 32'd0);
    tick;
    rst_l = 1'b1;
    run1("post_rst", 1'b0, 8'h80, 25'h0002000, 5'd10, 1'b0, 1'b0, 8'h76, 24'h800000, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
